// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction prefetch stage.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO holding fetched words with their PCs.
// Flush has priority over push/pop; push while full is accepted only with a pop.
module fetch_fifo
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fifo_entry_t              push_data_i,
  output fifo_entry_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fifo_entry_t      mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  // NOTE: the storage is reset too, so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction fetch stage: PC generation, req/gnt issue with credit, redirect/discard, output FIFO.
// Optional macro FETCH_ALIGN_CHECK_EN adds instr_err and the FAULT state for misaligned redirects.
module instr_prefetch
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        instr_err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, count;
  logic          credit, grant, push, pop, redirect_fault;
  logic [31:0]   redirect_pc_aligned;
  fifo_entry_t   push_entry, head;

  assign redirect_pc_aligned = redirect_pc & ~32'h3;
  assign credit   = ({1'b0, count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
  assign imem_req  = (state_q == FETCH) && enable && credit && !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign pop       = instr_valid && instr_ready && !redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_pend_q, fault_pend_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        fifo_full;
  assign redirect_fault = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fifo_full      = (count == CW'(DEPTH));
`else
  assign redirect_fault = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    discard_d     = discard_q;
    push          = 1'b0;
    push_entry    = '{pc: resp_pc_q, data: imem_rdata, err: 1'b0};

    if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;

    case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   if (!enable) state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Every word still in flight at a redirect belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      discard_d  = outstanding_d;
      if (redirect_fault)         state_d = FAULT;
      else if (state_q == FAULT)  state_d = enable ? FETCH : IDLE;
    end else if (imem_rvalid) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end else begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + PC_STEP;
      end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // In FAULT every response is already marked for discard, so this push never collides.
    fault_pend_d = fault_pend_q;
    fault_pc_d   = fault_pc_q;
    if (redirect_valid) begin
      fault_pend_d = redirect_fault;
      fault_pc_d   = redirect_pc;
    end else if (fault_pend_q && (!fifo_full || pop)) begin
      push         = 1'b1;
      push_entry   = '{pc: fault_pc_q, data: RV32_NOP, err: 1'b1};
      fault_pend_d = 1'b0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      fault_pend_q <= fault_pend_d;
      fault_pc_q   <= fault_pc_d;
    end
  end
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .push_data_i (push_entry),
    .head_o      (head),
    .count_o     (count)
  );

  assign instr_valid = (count != '0);
  assign instr_data  = head.data;
  assign instr_pc    = head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign instr_err = head.err;
`else
  logic unused_head_err;
  assign unused_head_err = head.err;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a fixed-latency in-order memory model.
// Honours FETCH_ALIGN_CHECK_EN to exercise the misaligned-redirect fault path.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        instr_err;
  localparam logic [31:0] BB_PC = 32'h0000_0200;
`else
  localparam logic [31:0] BB_PC = 32'h0000_0202;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  int gcount;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .instr_err      (instr_err)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_data"}, instr_data, mem_word(pc));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    next_cycle();
    rst = 1'b0; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    #1;
    if (chk) begin
      check("rst_req",   32'(imem_req),    32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_data",  instr_data,       32'd0);
      check("rst_pc",    instr_pc,         32'd0);
      check("rst_addr",  imem_addr,        32'd0);
    end
    repeat (2) next_cycle();
    rst = 1'b1;
  endtask

  // Memory: a grant in cycle k returns its word in cycle k+mem_lat.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        pend_addr.delete(); pend_due.delete();
        imem_rvalid = 1'b0; imem_rdata = '0;
      end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rvalid = 1'b0; imem_rdata = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values, then streaming with 1-cycle memory and a ready core.
    do_reset(1'b1);
    mem_lat = 1; imem_gnt = 1'b1; instr_ready = 1'b1; enable = 1'b1;
    #1;
    check("t1_idle_req", 32'(imem_req), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      next_cycle(); #1;
      if (i <= 8) begin
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, 32'(4 * (i - 1)));
      end
      if (i < 3) check("t1_valid_lat", 32'(instr_valid), 32'd0);
      else       expect_head("t1_head", 32'(4 * (i - 3)));
    end

    // Reset mid-stream: outputs clear at once, fetch restarts at RESET_PC.
    do_reset(1'b1);
    instr_ready = 1'b1; enable = 1'b1;
    next_cycle(); #1;
    check("t5_restart_addr", imem_addr, 32'd0);
    check("t5_restart_req", 32'(imem_req), 32'd1);
    next_cycle(); #1;
    next_cycle(); #1;
    expect_head("t5_head", 32'd0);

    // Core stalled: credit caps requests at DEPTH, then resumes at 16.
    do_reset(1'b0);
    mem_lat = 1; instr_ready = 1'b0; enable = 1'b1; gcount = 0;
    for (int i = 1; i <= 8; i++) begin
      next_cycle(); #1;
      if (imem_req && imem_gnt) gcount++;
    end
    check("t2_grants", 32'(gcount), 32'd4);
    check("t2_req_stall", 32'(imem_req), 32'd0);
    expect_head("t2_hold", 32'd0);
    for (int j = 0; j < 5; j++) begin
      next_cycle(); instr_ready = 1'b1; #1;
      expect_head("t2_drain", 32'(4 * j));
      if (j == 0) check("t2_still_full_req", 32'(imem_req), 32'd0);
      if (j == 1) begin
        check("t2_resume_req", 32'(imem_req), 32'd1);
        check("t2_resume_addr", imem_addr, 32'h10);
      end
    end

    // Redirect with rvalid and pop in the same cycle on an almost-full FIFO.
    do_reset(1'b0);
    mem_lat = 1; instr_ready = 1'b0; enable = 1'b1;
    repeat (4) next_cycle();
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1; #1;
    check("t4_pre_valid", 32'(instr_valid), 32'd1);
    check("t4_redir_req", 32'(imem_req), 32'd0);
    next_cycle(); redirect_valid = 1'b0; #1;
    check("t4_flushed", 32'(instr_valid), 32'd0);
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h40);
    next_cycle(); #1;
    check("t4_valid_lat", 32'(instr_valid), 32'd0);
    check("t4_addr2", imem_addr, 32'h44);
    next_cycle(); #1;
    expect_head("t4_head0", 32'h40);
    next_cycle(); #1;
    expect_head("t4_head1", 32'h44);

    // 3-cycle memory, redirect with two requests in flight.
    do_reset(1'b0);
    mem_lat = 3; instr_ready = 1'b1; enable = 1'b1;
    repeat (2) next_cycle();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("t3_redir_req", 32'(imem_req), 32'd0);
    next_cycle(); redirect_valid = 1'b0; #1;
    check("t3_addr0", imem_addr, 32'h100);
    check("t3_req0", 32'(imem_req), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      check("t3_stale_hidden", 32'(instr_valid), 32'd0);
      next_cycle(); #1;
      check("t3_addr", imem_addr, 32'h100 + 32'(4 * k));
    end
    check("t3_stale_hidden", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      expect_head("t3_head", 32'h100 + 32'(4 * k));
    end

    // Back-to-back redirects: the second wins, stale words all dropped.
    do_reset(1'b0);
    mem_lat = 3; instr_ready = 1'b1; enable = 1'b1;
    repeat (2) next_cycle();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    next_cycle(); redirect_pc = BB_PC; #1;
    check("t3b_redir_req", 32'(imem_req), 32'd0);
    next_cycle(); redirect_valid = 1'b0; #1;
    check("t3b_addr", imem_addr, 32'h200);
    repeat (3) begin
      next_cycle(); #1;
      check("t3b_stale_hidden", 32'(instr_valid), 32'd0);
    end
    next_cycle(); #1;
    expect_head("t3b_head0", 32'h200);
    next_cycle(); #1;
    expect_head("t3b_head1", 32'h204);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect: one NOP with err, no fetching until an aligned redirect.
    do_reset(1'b0);
    mem_lat = 1; instr_ready = 1'b1; enable = 1'b1;
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
    check("t6_redir_req", 32'(imem_req), 32'd0);
    next_cycle(); redirect_valid = 1'b0; #1;
    check("t6_req_a", 32'(imem_req), 32'd0);
    check("t6_valid_a", 32'(instr_valid), 32'd0);
    next_cycle(); #1;
    check("t6_err_valid", 32'(instr_valid), 32'd1);
    check("t6_err_pc", instr_pc, 32'h102);
    check("t6_err_data", instr_data, 32'h13);
    check("t6_err_flag", 32'(instr_err), 32'd1);
    check("t6_req_b", 32'(imem_req), 32'd0);
    repeat (3) begin
      next_cycle(); #1;
      check("t6_quiet_req", 32'(imem_req), 32'd0);
      check("t6_quiet_valid", 32'(instr_valid), 32'd0);
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    next_cycle(); redirect_valid = 1'b0; #1;
    check("t6_resume_req", 32'(imem_req), 32'd1);
    check("t6_resume_addr", imem_addr, 32'h200);
    next_cycle(); #1;
    next_cycle(); #1;
    expect_head("t6_head", 32'h200);
    check("t6_head_err", 32'(instr_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
